// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package riscv_mem_pkg;

    typedef enum logic [0:0] {
        ARB_CPU      = 1'b0,
        ARB_DBG_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } mem_owner_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    // True when addr falls inside the 2^(11+brams)-byte window starting at base.
    function automatic logic in_data_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned brams);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (11 + brams);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/riscv_dmem_arbiter_if.sv
// Bundle of requester (CPU, DBG) and data-memory signals around the arbiter.
interface riscv_dmem_arbiter_if;

    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_lock;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_resp_router.sv
// Remembers who owned last cycle's memory access and steers the memory's
// registered read data back to that requester only.
module dmem_resp_router
    import riscv_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  mem_owner_t       grant_owner_i,
    input  logic             grant_err_i,
    input  logic             grant_we_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [1:0]       rvalid_o,   // [0]=CPU, [1]=DBG
    output logic [1:0]       err_o,
    output logic [1:0][31:0] rdata_o
);

    mem_owner_t  resp_owner_q;
    logic        resp_err_q;
    logic        resp_we_q;
    logic [31:0] resp_rdata;

    // Capture the access granted this cycle; its data arrives next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_owner_q <= OWN_NONE;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_owner_q <= grant_owner_i;
            resp_err_q   <= grant_err_i && (grant_owner_i != OWN_NONE);
            resp_we_q    <= grant_we_i;
        end
    end

    // Out-of-range accesses never touched memory, so their data is forced to zero.
    assign resp_rdata = resp_err_q ? 32'd0 : mem_rdata_i;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        localparam mem_owner_t OWNER = (gi == 0) ? OWN_CPU : OWN_DBG;
        assign rvalid_o[gi] = (resp_owner_q == OWNER) && !resp_we_q;
        assign err_o[gi]    = (resp_owner_q == OWNER) && resp_err_q;
        assign rdata_o[gi]  = (resp_owner_q == OWNER) ? resp_rdata : 32'd0;
    end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-master arbiter (CPU, DBG) for the single data-memory port.
// CPU wins ties, DBG is forced through after MAX_WAIT denials, and a locked
// DBG grant keeps ownership until dbg_lock drops.
module riscv_dmem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int          DATA_BRAMS         = 2,
    parameter logic [31:0] DATA_START_ADDRESS = 32'h0080_0000,
    parameter int          MAX_WAIT           = 4
) (
    input logic                  clk,
    input logic                  rst,
    riscv_dmem_arbiter_if.slave  bus
);

    localparam int               WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    mem_owner_t  winner;
    logic        lock_active;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_in_range;
    logic        cpu_gnt;
    logic        dbg_gnt;

    logic [1:0]       resp_rvalid;
    logic [1:0]       resp_err;
    logic [1:0][31:0] resp_rdata;

    // The lock only holds while dbg_lock is still high; the release cycle
    // already arbitrates with normal CPU-first rules.
    assign lock_active = (state_q == ARB_DBG_LOCK) && bus.dbg_lock;

    // Pick this cycle's winner.
    always_comb begin
        winner = OWN_NONE;
        if (lock_active && bus.dbg_req) begin
            winner = OWN_DBG;
        end else if (bus.cpu_req && bus.dbg_req) begin
            winner = (wait_cnt_q == WAIT_MAX) ? OWN_DBG : OWN_CPU;
        end else if (bus.cpu_req) begin
            winner = OWN_CPU;
        end else if (bus.dbg_req) begin
            winner = OWN_DBG;
        end
    end

    assign cpu_gnt = (winner == OWN_CPU);
    assign dbg_gnt = (winner == OWN_DBG);

    // Route the winner's request onto the memory port; idle port is all zero.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = 32'd0;
        win_wdata = 32'd0;
        if (cpu_gnt) begin
            win_we    = bus.cpu_we;
            win_addr  = bus.cpu_addr;
            win_wdata = bus.cpu_wdata;
        end else if (dbg_gnt) begin
            win_we    = bus.dbg_we;
            win_addr  = bus.dbg_addr;
            win_wdata = bus.dbg_wdata;
        end
    end

    assign win_in_range = in_data_range(win_addr, DATA_START_ADDRESS, DATA_BRAMS);

    assign bus.mem_addr  = win_addr;
    assign bus.mem_wdata = win_wdata;
    assign bus.mem_we    = win_we && win_in_range;

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.cpu_stall = bus.cpu_req && !cpu_gnt;

    // Lock entry on a locked DBG grant, exit as soon as dbg_lock drops.
    always_comb begin
        state_d = state_q;
        if (state_q == ARB_CPU) begin
            if (dbg_gnt && bus.dbg_lock) begin
                state_d = ARB_DBG_LOCK;
            end
        end else if (!bus.dbg_lock) begin
            state_d = ARB_CPU;
        end
    end

    // Count consecutive DBG denials, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.dbg_req || dbg_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_CPU;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    dmem_resp_router u_resp_router (
        .clk           (clk),
        .rst           (rst),
        .grant_owner_i (winner),
        .grant_err_i   (!win_in_range),
        .grant_we_i    (win_we),
        .mem_rdata_i   (bus.mem_rdata),
        .rvalid_o      (resp_rvalid),
        .err_o         (resp_err),
        .rdata_o       (resp_rdata)
    );

    assign bus.cpu_rvalid = resp_rvalid[0];
    assign bus.cpu_err    = resp_err[0];
    assign bus.cpu_rdata  = resp_rdata[0];
    assign bus.dbg_rvalid = resp_rvalid[1];
    assign bus.dbg_err    = resp_err[1];
    assign bus.dbg_rdata  = resp_rdata[1];

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Self-checking bench for riscv_dmem_arbiter: grants are checked inline per
// cycle, responses through a scoreboard queue popped when they fall due.
module tb_riscv_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_dmem_arbiter_if bus();

    riscv_dmem_arbiter #(
        .DATA_BRAMS         (2),
        .DATA_START_ADDRESS (32'h0080_0000),
        .MAX_WAIT           (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read data memory (8 KB), with a bench-side preload port.
    logic [31:0] mem [0:2047];
    logic        pre_we = 1'b0;
    logic [10:0] pre_idx = '0;
    logic [31:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr[12:2]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[12:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference view of memory contents as the bench expects them.
    logic [31:0] model_mem [int];

    typedef struct {
        int          due;
        logic        cpu_rv, cpu_er, chk_cpu_rd;
        logic [31:0] cpu_rd;
        logic        dbg_rv, dbg_er, chk_dbg_rd;
        logic [31:0] dbg_rd;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Expected response for this cycle's access (owner 0=none,1=CPU,2=DBG).
    task automatic sb_push(input int owner, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic in_rng, err;
        logic [31:0] rd;
        in_rng = (addr[31:13] == 19'h00400);
        err    = (owner != 0) && !in_rng;
        rd     = 32'd0;
        if (owner != 0 && !we && in_rng) rd = model_mem[int'(addr[12:2])];
        if (owner != 0 && we && in_rng) model_mem[int'(addr[12:2])] = wdata;
        e.due = cyc + 1;
        e.cpu_rv = (owner == 1) && !we;
        e.cpu_er = (owner == 1) && err;
        e.cpu_rd = (owner == 1) ? rd : 32'd0;
        e.chk_cpu_rd = !((owner == 1) && we && in_rng);
        e.dbg_rv = (owner == 2) && !we;
        e.dbg_er = (owner == 2) && err;
        e.dbg_rd = (owner == 2) ? rd : 32'd0;
        e.chk_dbg_rd = !((owner == 2) && we && in_rng);
        sb_q.push_back(e);
    endtask

    // Response monitor: one line per completed transaction.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            $display("resp cyc=%0d cpu rv=%b err=%b rd=%h dbg rv=%b err=%b rd=%h", cyc,
                     bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata,
                     bus.dbg_rvalid, bus.dbg_err, bus.dbg_rdata);
            total_cnt++;
            if (bus.cpu_rvalid !== mon_e.cpu_rv || bus.cpu_err !== mon_e.cpu_er ||
                (mon_e.chk_cpu_rd && bus.cpu_rdata !== mon_e.cpu_rd))
                $display("FAIL resp_cpu cyc=%0d got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
                         cyc, bus.cpu_rvalid, bus.cpu_err, bus.cpu_rdata,
                         mon_e.cpu_rv, mon_e.cpu_er, mon_e.cpu_rd);
            else pass_cnt++;
            total_cnt++;
            if (bus.dbg_rvalid !== mon_e.dbg_rv || bus.dbg_err !== mon_e.dbg_er ||
                (mon_e.chk_dbg_rd && bus.dbg_rdata !== mon_e.dbg_rd))
                $display("FAIL resp_dbg cyc=%0d got rv=%b err=%b rd=%h want rv=%b err=%b rd=%h",
                         cyc, bus.dbg_rvalid, bus.dbg_err, bus.dbg_rdata,
                         mon_e.dbg_rv, mon_e.dbg_er, mon_e.dbg_rd);
            else pass_cnt++;
        end
    end

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd, input logic dlock);
        bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
        bus.dbg_req = dreq; bus.dbg_we = dwe; bus.dbg_addr = daddr; bus.dbg_wdata = dwd;
        bus.dbg_lock = dlock;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        sb_push(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pre_we = 1'b1; pre_idx = 11'd4; pre_data = 32'hDEAD_BEEF;
        model_mem[4] = 32'hDEAD_BEEF;
        tick();
        pre_we = 1'b0;
        tick();
        @(negedge clk);
        total_cnt++;
        if ({bus.cpu_gnt, bus.cpu_stall, bus.cpu_rvalid, bus.cpu_err,
             bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_err, bus.mem_we} !== 8'b0)
            $display("FAIL reset_flags got %b want 00000000",
                     {bus.cpu_gnt, bus.cpu_stall, bus.cpu_rvalid, bus.cpu_err,
                      bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_err, bus.mem_we});
        else pass_cnt++;
        total_cnt++;
        if (bus.cpu_rdata !== 32'd0 || bus.dbg_rdata !== 32'd0 || bus.mem_addr !== 32'd0)
            $display("FAIL reset_data got cpu=%h dbg=%h addr=%h want 0",
                     bus.cpu_rdata, bus.dbg_rdata, bus.mem_addr);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        drive(1, 0, 32'h0080_0010, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total_cnt++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall} !== 3'b100)
            $display("FAIL single_read_gnt got %b want 100", {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall});
        else pass_cnt++;
        sb_push(1, 0, 32'h0080_0010, 0);
        tick();
        idle_cycle();
    endtask

    task automatic test_fairness();
        logic exp_dbg;
        for (int i = 0; i < 10; i++) begin
            exp_dbg = (i % 5 == 4);
            drive(1, 0, 32'h0080_0010, 0, 1, 0, 32'h0080_0010, 0, 0);
            @(negedge clk);
            total_cnt++;
            if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall} !== {~exp_dbg, exp_dbg, exp_dbg})
                $display("FAIL fairness_gnt i=%0d got %b want %b", i,
                         {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall}, {~exp_dbg, exp_dbg, exp_dbg});
            else pass_cnt++;
            sb_push(exp_dbg ? 2 : 1, 0, 32'h0080_0010, 0);
            tick();
        end
        idle_cycle();
    endtask

    task automatic test_lock();
        logic exp_dbg;
        for (int i = 0; i < 8; i++) begin
            exp_dbg = (i >= 4 && i <= 6);
            drive(1, 0, 32'h0080_0010, 0, 1, 0, 32'h0080_0010, 0, (i < 7));
            @(negedge clk);
            total_cnt++;
            if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall} !== {~exp_dbg, exp_dbg, exp_dbg})
                $display("FAIL lock_gnt i=%0d got %b want %b", i,
                         {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall}, {~exp_dbg, exp_dbg, exp_dbg});
            else pass_cnt++;
            sb_push(exp_dbg ? 2 : 1, 0, 32'h0080_0010, 0);
            tick();
        end
        idle_cycle();
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 32'h0090_0000, 32'h1234_5678, 0, 0, 0, 0, 0);
        @(negedge clk);
        total_cnt++;
        if ({bus.cpu_gnt, bus.mem_we} !== 2'b10)
            $display("FAIL oor_write got gnt,we=%b want 10", {bus.cpu_gnt, bus.mem_we});
        else pass_cnt++;
        sb_push(1, 1, 32'h0090_0000, 32'h1234_5678);
        tick();
        drive(1, 0, 32'h0090_0000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        sb_push(1, 0, 32'h0090_0000, 0);
        tick();
        idle_cycle();
    endtask

    task automatic test_write_read();
        drive(0, 0, 0, 0, 1, 1, 32'h0080_0004, 32'hA5A5_A5A5, 0);
        @(negedge clk);
        total_cnt++;
        if ({bus.dbg_gnt, bus.mem_we} !== 2'b11 || bus.mem_wdata !== 32'hA5A5_A5A5)
            $display("FAIL dbg_write got gnt,we=%b wdata=%h want 11 a5a5a5a5",
                     {bus.dbg_gnt, bus.mem_we}, bus.mem_wdata);
        else pass_cnt++;
        sb_push(2, 1, 32'h0080_0004, 32'hA5A5_A5A5);
        tick();
        drive(1, 0, 32'h0080_0004, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        sb_push(1, 0, 32'h0080_0004, 0);
        tick();
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_g [6];
        exp_g = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1, 1, 32'h0080_0020, 32'h1111_1111, 0, 0, 0, 0, 0);
                1: drive(0, 0, 0, 0, 1, 1, 32'h0080_0024, 32'h2222_2222, 0);
                2: drive(1, 0, 32'h0080_0024, 0, 0, 0, 0, 0, 0);
                3: drive(0, 0, 0, 0, 1, 0, 32'h0080_0020, 0, 0);
                4: drive(1, 1, 32'h0080_0020, 32'h3333_3333, 1, 0, 32'h0080_0024, 0, 0);
                default: drive(0, 0, 0, 0, 1, 0, 32'h0080_0020, 0, 0);
            endcase
            @(negedge clk);
            total_cnt++;
            if ({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall} !== exp_g[i])
                $display("FAIL b2b_gnt i=%0d got %b want %b", i,
                         {bus.cpu_gnt, bus.dbg_gnt, bus.cpu_stall}, exp_g[i]);
            else pass_cnt++;
            if (exp_g[i][2]) sb_push(1, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata);
            else             sb_push(2, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata);
            tick();
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        logic exp_dbg;
        drive(1, 0, 32'h0080_0010, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total_cnt++;
        if (bus.cpu_gnt !== 1'b1)
            $display("FAIL rstmid_gnt got %b want 1", bus.cpu_gnt);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF)
            $display("FAIL rstmid_pre got rv=%b rd=%h want 1 deadbeef", bus.cpu_rvalid, bus.cpu_rdata);
        else pass_cnt++;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'd0 || bus.cpu_err !== 1'b0)
            $display("FAIL rstmid_drop got rv=%b rd=%h err=%b want 0 0 0",
                     bus.cpu_rvalid, bus.cpu_rdata, bus.cpu_err);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_dbg = (i == 4);
            drive(1, 0, 32'h0080_0010, 0, 1, 0, 32'h0080_0010, 0, 0);
            @(negedge clk);
            total_cnt++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== {~exp_dbg, exp_dbg})
                $display("FAIL post_reset_gnt i=%0d got %b want %b", i,
                         {bus.cpu_gnt, bus.dbg_gnt}, {~exp_dbg, exp_dbg});
            else pass_cnt++;
            sb_push(exp_dbg ? 2 : 1, 0, 32'h0080_0010, 0);
            tick();
        end
        idle_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_lock();
        test_out_of_range();
        test_write_read();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
